// File: rtl/text_console_writer.sv
// Character-stream front end for the 80x30 text VRAM: decodes control bytes,
// tracks the cursor and drives Avalon-MM writes, including hardware scroll.
module text_console_writer #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int VRAM_BASE    = 0,
    parameter int READ_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CHAR_VALID,
    input  logic [7:0]  CHAR_DATA,
    output logic        CHAR_READY,
    input  logic [3:0]  ATTR_FG,
    input  logic [3:0]  ATTR_BG,
    input  logic        ATTR_INV,
    output logic [11:0] M_ADDR,
    output logic        M_READ,
    output logic        M_WRITE,
    output logic [3:0]  M_BYTE_EN,
    output logic [31:0] M_WRITEDATA,
    input  logic [31:0] M_READDATA,
    input  logic        M_WAITREQUEST,
    output logic [6:0]  CURSOR_X,
    output logic [4:0]  CURSOR_Y,
    output logic        BUSY
);
    localparam int ROW_WORDS   = COLS / 2;
    localparam int TOTAL_WORDS = ROWS * COLS / 2;
    localparam logic [10:0] FIRST_SRC      = 11'(ROW_WORDS);
    localparam logic [10:0] LAST_WORD      = 11'(TOTAL_WORDS - 1);
    localparam logic [10:0] LAST_ROW_START = 11'(TOTAL_WORDS - ROW_WORDS);
    localparam logic [6:0]  X_MAX          = 7'(COLS - 1);
    localparam logic [4:0]  Y_MAX          = 5'(ROWS - 1);
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_WR_CHAR, S_SCROLL_RD, S_SCROLL_WAIT, S_SCROLL_WR, S_CLEAR
    } state_t;

    state_t            state, state_nxt;
    logic              started;
    logic [6:0]        cur_x;
    logic [4:0]        cur_y;
    logic [10:0]       word_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic              bs_p0;
    logic              clr_all;
    logic [7:0]        char_p0;
    logic [3:0]        fg_p0, bg_p0;
    logic              inv_p0;
    logic [31:0]       rd_word_p1;

    logic        accept, is_print, bus_done, at_eol, at_bottom, last_word, lat_done;
    logic [15:0] blank_hw, char_hw;
    logic [11:0] char_addr, word_addr;

    assign accept    = CHAR_VALID && CHAR_READY;
    assign is_print  = (char_p0 >= 8'h20) && (char_p0 <= 8'h7E);
    assign bus_done  = !M_WAITREQUEST;
    assign at_eol    = (cur_x == X_MAX);
    assign at_bottom = (cur_y == Y_MAX);
    assign last_word = (word_cnt == LAST_WORD);
    assign lat_done  = (lat_cnt == LAT_LAST);
    assign blank_hw  = {inv_p0, 7'h20, fg_p0, bg_p0};
    assign char_hw   = bs_p0 ? blank_hw : {inv_p0, char_p0[6:0], fg_p0, bg_p0};
    assign char_addr = 12'(VRAM_BASE) + 12'(cur_y) * 12'(ROW_WORDS) + 12'(cur_x[6:1]);
    assign word_addr = 12'(VRAM_BASE) + {1'b0, word_cnt};
    assign CURSOR_X  = cur_x;
    assign CURSOR_Y  = cur_y;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= S_IDLE;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (accept) state_nxt = S_DECODE;
            S_DECODE: begin
                case (char_p0)
                    8'h0D:   state_nxt = S_IDLE;
                    8'h0A:   state_nxt = at_bottom ? S_SCROLL_RD : S_IDLE;
                    8'h08:   state_nxt = (cur_x != 7'd0) ? S_WR_CHAR : S_IDLE;
                    8'h0C:   state_nxt = S_CLEAR;
                    default: state_nxt = is_print ? S_WR_CHAR : S_IDLE;
                endcase
            end
            S_WR_CHAR:
                if (bus_done)
                    state_nxt = (!bs_p0 && at_eol && at_bottom) ? S_SCROLL_RD : S_IDLE;
            S_SCROLL_RD:   if (bus_done) state_nxt = S_SCROLL_WAIT;
            S_SCROLL_WAIT: if (lat_done) state_nxt = S_SCROLL_WR;
            S_SCROLL_WR:   if (bus_done) state_nxt = last_word ? S_CLEAR : S_SCROLL_RD;
            S_CLEAR:       if (bus_done && last_word) state_nxt = S_IDLE;
            default:       state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        CHAR_READY  = started && (state == S_IDLE);
        BUSY        = started && (state != S_IDLE);
        M_ADDR      = '0;
        M_READ      = 1'b0;
        M_WRITE     = 1'b0;
        M_BYTE_EN   = '0;
        M_WRITEDATA = '0;
        case (state)
            S_WR_CHAR: begin
                M_WRITE     = 1'b1;
                M_ADDR      = char_addr;
                M_BYTE_EN   = cur_x[0] ? 4'b1100 : 4'b0011;
                M_WRITEDATA = {char_hw, char_hw};
            end
            S_SCROLL_RD: begin
                M_READ = 1'b1;
                M_ADDR = word_addr;
            end
            S_SCROLL_WR: begin
                M_WRITE     = 1'b1;
                M_ADDR      = word_addr - 12'(ROW_WORDS);
                M_BYTE_EN   = 4'b1111;
                M_WRITEDATA = rd_word_p1;
            end
            S_CLEAR: begin
                M_WRITE     = 1'b1;
                M_ADDR      = word_addr;
                M_BYTE_EN   = 4'b1111;
                M_WRITEDATA = {blank_hw, blank_hw};
            end
            default: ;
        endcase
    end

    // Cursor and word counter move only on the edge that completes a bus command
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cur_x    <= '0;
            cur_y    <= '0;
            word_cnt <= '0;
            lat_cnt  <= '0;
            bs_p0    <= 1'b0;
            clr_all  <= 1'b0;
        end else begin
            case (state)
                S_DECODE: begin
                    bs_p0 <= (char_p0 == 8'h08);
                    case (char_p0)
                        8'h0D: cur_x <= '0;
                        8'h0A: begin
                            cur_x <= '0;
                            if (!at_bottom) cur_y <= cur_y + 5'd1;
                            else            word_cnt <= FIRST_SRC;
                        end
                        8'h08: if (cur_x != 7'd0) cur_x <= cur_x - 7'd1;
                        8'h0C: begin
                            word_cnt <= '0;
                            clr_all  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_WR_CHAR: begin
                    if (bus_done && !bs_p0) begin
                        if (at_eol) begin
                            cur_x <= '0;
                            if (!at_bottom) cur_y <= cur_y + 5'd1;
                            else            word_cnt <= FIRST_SRC;
                        end else begin
                            cur_x <= cur_x + 7'd1;
                        end
                    end
                end
                S_SCROLL_RD:   if (bus_done) lat_cnt <= '0;
                S_SCROLL_WAIT: lat_cnt <= lat_cnt + LAT_W'(1);
                S_SCROLL_WR: begin
                    if (bus_done) begin
                        if (last_word) begin
                            word_cnt <= LAST_ROW_START;
                            clr_all  <= 1'b0;
                        end else begin
                            word_cnt <= word_cnt + 11'd1;
                        end
                    end
                end
                S_CLEAR: begin
                    if (bus_done) begin
                        if (last_word) begin
                            if (clr_all) begin
                                cur_x <= '0;
                                cur_y <= '0;
                            end
                        end else begin
                            word_cnt <= word_cnt + 11'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            char_p0 <= CHAR_DATA;
            fg_p0   <= ATTR_FG;
            bg_p0   <= ATTR_BG;
            inv_p0  <= ATTR_INV;
        end
        if (state == S_SCROLL_WAIT && lat_done)
            rd_word_p1 <= M_READDATA;
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: a VRAM slave model plus a scoreboard of
// expected Avalon transactions derived from a reference cursor/screen model.
module tb_text_console_writer;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        CHAR_VALID;
    logic [7:0]  CHAR_DATA;
    logic        CHAR_READY;
    logic [3:0]  ATTR_FG, ATTR_BG;
    logic        ATTR_INV;
    logic [11:0] M_ADDR;
    logic        M_READ, M_WRITE;
    logic [3:0]  M_BYTE_EN;
    logic [31:0] M_WRITEDATA;
    logic [31:0] M_READDATA;
    logic        M_WAITREQUEST;
    logic [6:0]  CURSOR_X;
    logic [4:0]  CURSOR_Y;
    logic        BUSY;

    typedef struct packed {
        logic        rd;
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } txn_t;

    txn_t        sb[$];
    logic [31:0] mem   [0:4095];
    logic [31:0] model [0:4095];
    int checks = 0;
    int errors = 0;
    int cx = 0;
    int cy = 0;

    text_console_writer dut (
        .CLK(CLK), .RESET(RESET), .CHAR_VALID(CHAR_VALID), .CHAR_DATA(CHAR_DATA),
        .CHAR_READY(CHAR_READY), .ATTR_FG(ATTR_FG), .ATTR_BG(ATTR_BG), .ATTR_INV(ATTR_INV),
        .M_ADDR(M_ADDR), .M_READ(M_READ), .M_WRITE(M_WRITE), .M_BYTE_EN(M_BYTE_EN),
        .M_WRITEDATA(M_WRITEDATA), .M_READDATA(M_READDATA), .M_WAITREQUEST(M_WAITREQUEST),
        .CURSOR_X(CURSOR_X), .CURSOR_Y(CURSOR_Y), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] pat(int i);
        return 32'(i) * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    // Slave: read data appears one cycle after acceptance
    always @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
            M_READDATA <= '0;
        end else begin
            if (M_READ && !M_WAITREQUEST) M_READDATA <= mem[M_ADDR];
            if (M_WRITE && !M_WAITREQUEST)
                for (int b = 0; b < 4; b++)
                    if (M_BYTE_EN[b]) mem[M_ADDR][8*b +: 8] <= M_WRITEDATA[8*b +: 8];
        end
    end

    always @(negedge CLK) begin
        if (RESET && (M_READ || M_WRITE) && !M_WAITREQUEST) begin
            txn_t t;
            checks++;
            if (M_READ && M_WRITE) begin
                errors++;
                $display("FAIL bus_rw_overlap got read=1 write=1 expected exclusive");
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL bus_unexpected got rd=%0b addr=%0d data=%h expected no transaction",
                         M_READ, M_ADDR, M_WRITEDATA);
            end else begin
                t = sb.pop_front();
                if (M_READ !== t.rd || M_ADDR !== t.addr ||
                    (!t.rd && (M_BYTE_EN !== t.be || M_WRITEDATA !== t.data))) begin
                    errors++;
                    $display("FAIL bus_txn got rd=%0b addr=%0d be=%b data=%h expected rd=%0b addr=%0d be=%b data=%h",
                             M_READ, M_ADDR, M_BYTE_EN, M_WRITEDATA, t.rd, t.addr, t.be, t.data);
                end
            end
        end
    end

    function automatic void push_txn(logic rd, int addr, logic [3:0] be, logic [31:0] data);
        txn_t t;
        t.rd = rd; t.addr = 12'(addr); t.be = be; t.data = data;
        sb.push_back(t);
        if (!rd)
            for (int b = 0; b < 4; b++)
                if (be[b]) model[addr][8*b +: 8] = data[8*b +: 8];
    endfunction

    function automatic void line_adv(logic [15:0] blank);
        if (cy < 29) begin
            cy++;
        end else begin
            for (int i = 40; i < 1200; i++) begin
                push_txn(1'b1, i, 4'b0000, 32'h0);
                push_txn(1'b0, i - 40, 4'b1111, model[i]);
            end
            for (int i = 1160; i < 1200; i++) push_txn(1'b0, i, 4'b1111, {blank, blank});
        end
    endfunction

    function automatic void model_char(logic [7:0] c, logic [3:0] fg, logic [3:0] bg, logic inv);
        logic [15:0] blank;
        logic [15:0] hw;
        blank = {inv, 7'h20, fg, bg};
        hw    = {inv, c[6:0], fg, bg};
        if (c >= 8'h20 && c <= 8'h7E) begin
            push_txn(1'b0, cy * 40 + cx / 2, (cx % 2 == 1) ? 4'b1100 : 4'b0011, {hw, hw});
            cx++;
            if (cx == 80) begin
                cx = 0;
                line_adv(blank);
            end
        end else if (c == 8'h0D) begin
            cx = 0;
        end else if (c == 8'h0A) begin
            cx = 0;
            line_adv(blank);
        end else if (c == 8'h08) begin
            if (cx > 0) begin
                cx--;
                push_txn(1'b0, cy * 40 + cx / 2, (cx % 2 == 1) ? 4'b1100 : 4'b0011, {blank, blank});
            end
        end else if (c == 8'h0C) begin
            for (int i = 0; i < 1200; i++) push_txn(1'b0, i, 4'b1111, {blank, blank});
            cx = 0;
            cy = 0;
        end
    endfunction

    // Called #1 after a rising edge; returns #1 after the accepting edge
    task automatic send_char(input logic [7:0] c, input logic [3:0] fg, input logic [3:0] bg,
                             input logic inv);
        int n = 0;
        while (!CHAR_READY && n < 5000) begin
            @(posedge CLK); #1; n++;
        end
        if (!CHAR_READY) begin
            checks++; errors++;
            $display("FAIL ready_timeout got CHAR_READY=0 expected 1 within 5000 cycles");
        end
        model_char(c, fg, bg, inv);
        CHAR_VALID = 1'b1; CHAR_DATA = c; ATTR_FG = fg; ATTR_BG = bg; ATTR_INV = inv;
        @(posedge CLK); #1;
        CHAR_VALID = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(CHAR_READY && sb.size() == 0) && n < 10000) begin
            @(posedge CLK); #1; n++;
        end
        checks++;
        if (!CHAR_READY || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_done got ready=%0b pending=%0d expected ready=1 pending=0",
                     name, CHAR_READY, sb.size());
        end
    endtask

    task automatic check_cursor(input string name);
        checks++;
        if (CURSOR_X !== 7'(cx) || CURSOR_Y !== 5'(cy)) begin
            errors++;
            $display("FAIL %s_cursor got (%0d,%0d) expected (%0d,%0d)",
                     name, CURSOR_X, CURSOR_Y, cx, cy);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0; CHAR_VALID = 1'b0; CHAR_DATA = '0; ATTR_FG = '0; ATTR_BG = '0;
        ATTR_INV = 1'b0; M_WAITREQUEST = 1'b0;
        for (int i = 0; i < 4096; i++) model[i] = pat(i);
        #1;
        checks++;
        if ({M_ADDR, M_READ, M_WRITE, M_BYTE_EN, M_WRITEDATA, CHAR_READY, CURSOR_X, CURSOR_Y, BUSY} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got addr=%0d rd=%0b wr=%0b ready=%0b busy=%0b cur=(%0d,%0d) expected all 0",
                     M_ADDR, M_READ, M_WRITE, CHAR_READY, BUSY, CURSOR_X, CURSOR_Y);
        end
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b1;
        #1;
        checks++;
        if (CHAR_READY !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready got %0b expected 0 before first edge", CHAR_READY);
        end
        @(posedge CLK); #1;
        checks++;
        if (CHAR_READY !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_edge got ready=%0b busy=%0b expected ready=1 busy=0", CHAR_READY, BUSY);
        end
        check_cursor("reset");
    endtask

    task automatic test_print_ab();
        send_char(8'h41, 4'hF, 4'h0, 1'b0);
        checks++;
        if (M_WRITE !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL decode_cycle got write=%0b busy=%0b expected write=0 busy=1", M_WRITE, BUSY);
        end
        @(posedge CLK); #1;
        checks++;
        if (M_WRITE !== 1'b1 || CHAR_READY !== 1'b0) begin
            errors++;
            $display("FAIL write_cycle got write=%0b ready=%0b expected write=1 ready=0", M_WRITE, CHAR_READY);
        end
        @(posedge CLK); #1;
        checks++;
        if (CHAR_READY !== 1'b1) begin
            errors++;
            $display("FAIL ready_return got %0b expected 1 three edges after accept", CHAR_READY);
        end
        check_cursor("char_a");
        send_char(8'h42, 4'hF, 4'h0, 1'b0);
        wait_done("char_b");
        check_cursor("char_b");
    endtask

    task automatic test_form_feed_and_bs_home();
        send_char(8'h0C, 4'h2, 4'h5, 1'b1);
        wait_done("form_feed");
        check_cursor("form_feed");
        send_char(8'h08, 4'h1, 4'h1, 1'b0);
        wait_done("bs_home");
        check_cursor("bs_home");
    endtask

    task automatic test_line_wrap();
        for (int i = 0; i < 80; i++) send_char(8'(8'h20 + (i % 95)), 4'(i), 4'(i + 3), i[0]);
        wait_done("row_fill");
        check_cursor("row_fill");
        send_char(8'h7E, 4'h9, 4'h6, 1'b0);
        wait_done("char_81");
        check_cursor("char_81");
    endtask

    task automatic test_controls();
        send_char(8'h08, 4'h3, 4'h4, 1'b1);
        wait_done("backspace");
        check_cursor("backspace");
        send_char(8'h58, 4'h7, 4'h0, 1'b0);
        send_char(8'h0D, 4'h7, 4'h0, 1'b0);
        wait_done("cr");
        check_cursor("cr");
        send_char(8'h01, 4'h7, 4'h0, 1'b0);
        wait_done("ignored");
        for (int i = 0; i < 28; i++) send_char(8'h0A, 4'hF, 4'h0, 1'b0);
        for (int i = 0; i < 5; i++) send_char(8'h30 + 8'(i), 4'hC, 4'h1, 1'b0);
        wait_done("to_bottom");
        check_cursor("to_bottom");
    endtask

    task automatic test_scroll();
        int  n = 0;
        bit  ready_seen = 1'b0;
        send_char(8'h0A, 4'hF, 4'h0, 1'b0);
        while (sb.size() != 0 && n < 10000) begin
            if (CHAR_READY) ready_seen = 1'b1;
            @(posedge CLK); #1; n++;
        end
        checks++;
        if (ready_seen) begin
            errors++;
            $display("FAIL scroll_ready got CHAR_READY=1 during scroll expected 0");
        end
        wait_done("scroll");
        check_cursor("scroll");
    endtask

    task automatic test_waitrequest();
        logic [11:0] a0;
        logic [31:0] d0;
        logic [3:0]  b0;
        send_char(8'h5A, 4'h8, 4'h2, 1'b1);
        M_WAITREQUEST = 1'b1;
        @(posedge CLK); #1;
        a0 = M_ADDR; d0 = M_WRITEDATA; b0 = M_BYTE_EN;
        checks++;
        if (M_WRITE !== 1'b1) begin
            errors++;
            $display("FAIL stall_start got write=%0b expected 1", M_WRITE);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            checks++;
            if (M_WRITE !== 1'b1 || M_ADDR !== a0 || M_WRITEDATA !== d0 || M_BYTE_EN !== b0 ||
                CURSOR_X !== 7'(cx - 1)) begin
                errors++;
                $display("FAIL stall_hold got wr=%0b addr=%0d data=%h be=%b x=%0d expected wr=1 addr=%0d data=%h be=%b x=%0d",
                         M_WRITE, M_ADDR, M_WRITEDATA, M_BYTE_EN, CURSOR_X, a0, d0, b0, cx - 1);
            end
        end
        M_WAITREQUEST = 1'b0;
        wait_done("stall");
        check_cursor("stall");
    endtask

    task automatic test_reset_mid_scroll();
        send_char(8'h0A, 4'hF, 4'h0, 1'b0);
        repeat (100) @(posedge CLK);
        #2;
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL midscroll_busy got %0b expected 1", BUSY);
        end
        RESET = 1'b0;
        #1;
        checks++;
        if (M_READ !== 1'b0 || M_WRITE !== 1'b0 || CHAR_READY !== 1'b0 ||
            CURSOR_X !== 7'd0 || CURSOR_Y !== 5'd0) begin
            errors++;
            $display("FAIL async_abort got rd=%0b wr=%0b ready=%0b cur=(%0d,%0d) expected 0 0 0 (0,0)",
                     M_READ, M_WRITE, CHAR_READY, CURSOR_X, CURSOR_Y);
        end
        sb.delete();
        cx = 0; cy = 0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (CHAR_READY !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL abort_release got ready=%0b busy=%0b expected ready=1 busy=0", CHAR_READY, BUSY);
        end
        check_cursor("abort");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_print_ab();
        test_form_feed_and_bs_home();
        test_line_wrap();
        test_controls();
        test_scroll();
        test_waitrequest();
        test_reset_mid_scroll();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Upstream feeder for the VGA text-mode display. Turns a byte stream of characters into Avalon-MM writes to the 80x30 VRAM.
- VRAM layout: 2 characters per 32-bit word, word address = row*40 + col/2.
- Each character half-word is [15] IV, [14:8] code, [7:4] FG index, [3:0] BG index. Even column uses bits [15:0]; odd column uses bits [31:16].
- Maintains a cursor and handles CR, LF, backspace and form feed. Scrolls the screen by hardware read-modify-copy over the same Avalon port.

Parameters:
- COLS, 80, characters per row; must be even.
- ROWS, 30, character rows.
- VRAM_BASE, 0, word address of cell (0,0); bit 11 must be 0.
- READ_LATENCY, 1, fixed slave read latency in cycles.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RESET  in  1  asynchronous, active-low reset.
- CHAR_VALID  in  1  character offered.
- CHAR_DATA  in  8  character byte.
- CHAR_READY  out  1  block can accept a character.
- ATTR_FG  in  4  foreground palette index; sampled with the character.
- ATTR_BG  in  4  background palette index; sampled with the character.
- ATTR_INV  in  1  inverse bit; sampled with the character.
- M_ADDR  out  12  Avalon master word address.
- M_READ  out  1  Avalon read.
- M_WRITE  out  1  Avalon write.
- M_BYTE_EN  out  4  byte enables.
- M_WRITEDATA  out  32  write data.
- M_READDATA  in  32  read data.
- M_WAITREQUEST  in  1  slave stall.
- CURSOR_X  out  7  cursor column.
- CURSOR_Y  out  5  cursor row.
- BUSY  out  1  block not in IDLE.

Behaviour:
- Reset:
  - All outputs are 0 and the cursor is (0,0); state is IDLE.
  - Assertion mid-operation aborts immediately: M_READ/M_WRITE drop, no completion.
  - CHAR_READY rises on the first CLK edge after release.
- Input handshake:
  - CHAR_READY = (state==IDLE).
  - A transfer occurs when CHAR_VALID & CHAR_READY. CHAR_DATA and the attributes are latched on that edge.
- Avalon master rules:
  - A command is held with stable address, data and byte enables while M_WAITREQUEST=1. It completes on the first cycle M_WAITREQUEST=0.
  - Read data is sampled exactly READ_LATENCY cycles after read acceptance.
  - M_READ and M_WRITE are never asserted together.
- Character classes:
  - Printable (0x20-0x7E):
    - Half-word = {INV, CHAR_DATA[6:0], FG, BG} at (x,y).
    - M_BYTE_EN = 4'b0011 for even x, 4'b1100 for odd x. The half-word is replicated to both halves of M_WRITEDATA.
    - After write completion x+1. If x was COLS-1: x=0, then line-advance.
  - 0x0D: x=0. No bus traffic.
  - 0x0A: x=0, then line-advance.
  - 0x08:
    - If x>0: x-1, then write a blank at the new x.
    - If x=0: no-op.
  - 0x0C: clear all ROWS*COLS/2 words with the blank word, then cursor (0,0).
  - Others: consumed, ignored.
- Blank half-word = {INV, 7'h20, FG, BG}, using the attributes latched with the triggering character.
- Line-advance:
  - If y<ROWS-1: y+1.
  - Else SCROLL:
    - For i = COLS/2 .. ROWS*COLS/2-1: read word i, then write it to word i-COLS/2 with M_BYTE_EN 4'b1111.
    - Then write blank words to the last row's COLS/2 words.
    - y stays ROWS-1.
- Addresses are VRAM_BASE + index, with 12-bit wrap ignored (range guaranteed by parameters).
- States:
  - IDLE -> DECODE on accept.
  - DECODE -> WR_CHAR / CLEAR / SCROLL_RD / IDLE per class.
  - WR_CHAR -> IDLE or SCROLL_RD on completion.
  - SCROLL_RD -> SCROLL_WAIT on read accept.
  - SCROLL_WAIT -> SCROLL_WR after READ_LATENCY.
  - SCROLL_WR -> SCROLL_RD while words remain, else CLEAR (last row).
  - CLEAR -> IDLE after last word.
- Timing:
  - Printable character accepted at edge T: M_WRITE high in cycle T+2 (one DECODE cycle). With no stall, CHAR_READY returns at T+3.
  - Cursor outputs update on the completing edge.
- Width rules: word counter 11 bits; x in 0..COLS-1; y in 0..ROWS-1.
- BUSY = ~CHAR_READY after reset.

Test Plan:
- Reset, then send 0x41 (FG=F, BG=0, INV=0) -> one write: addr 0, BE 0011, WRITEDATA[15:0]=0x41F0; cursor (1,0).
- Follow with 0x42 -> addr 0, BE 1100, WRITEDATA[31:16]=0x42F0; cursor (2,0).
- 80 printable characters from (0,0) -> cursor (0,1). The 81st character writes addr 40, BE 0011.
- Cursor (5,29), send 0x0A -> 1160 reads (addr 40..1199) each followed by a write to addr-40 (BE 1111), then 40 writes of 0x20F020F0 to addr 1160..1199. CHAR_READY low throughout; final cursor (0,29).
- Hold M_WAITREQUEST=1 for 5 cycles during a character write -> M_ADDR, M_WRITEDATA and M_BYTE_EN stable; exactly one write completes; cursor advances once.
- Backspace at (0,0) -> no bus traffic.
- 0x0C -> 1200 blank writes, cursor (0,0).
- RESET low mid-scroll -> M_READ/M_WRITE drop asynchronously; cursor (0,0); CHAR_READY=1 one edge after release.
